write_buffer: RTL

Data-memory write buffer between the core's EX/MEM stage outputs and the data memory. It queues stores in a FIFO, drains them to memory with a req/ack handshake, forwards buffered data to matching loads, and fetches load misses from memory. It stalls the pipeline only when the FIFO is full or a load misses.

---
 rtl/write_buffer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/write_buffer.sv
// write_buffer: store queue between the EX/MEM stage and data memory.
//
// Stores are queued in a DEPTH-entry FIFO and drained to memory one at a time
// over a req/ack handshake. Loads that match a queued store are served from
// the youngest matching entry with no memory access; loads that miss stall the
// core while a read is fetched, and reads take priority over pending drains.
//
// Ports:
//   clock, resetN              clock and asynchronous active-low reset
//   memWrite, memRead          store / load request from EX/MEM (exclusive)
//   address, writeData         request word address and store data
//   readData                   load result (valid when stall=0 and memRead=1)
//   stall                      combinational core freeze
//   memReq, memWe              registered memory request and write enable
//   memAddress, memWriteData   registered transaction address / write data
//   memReadData, memAck        memory read data and single-cycle completion
//   empty, count               FIFO occupancy

module write_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       memWrite,
    input  logic                       memRead,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [DATA_WIDTH-1:0]      writeData,
    output logic [DATA_WIDTH-1:0]      readData,
    output logic                       stall,
    output logic                       memReq,
    output logic                       memWe,
    output logic [ADDR_WIDTH-1:0]      memAddress,
    output logic [DATA_WIDTH-1:0]      memWriteData,
    input  logic [DATA_WIDTH-1:0]      memReadData,
    input  logic                       memAck,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic                  load_done_q;
    logic [DATA_WIDTH-1:0] load_data_q;

    logic                  mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [PW-1:0]         scan_idx;
    logic                  miss_pending;
    logic                  start_write;
    logic                  start_read;
    logic                  read_done;

    assign full = (count_q == CW'(DEPTH));
    // A full store waits even if the head pops on this edge.
    assign push = memWrite && !full;
    assign pop  = (state_q == StWrite) && memAck;

    // Scan oldest to youngest so the last match (youngest store) wins. The
    // head entry stays visible in the cycle it is popped.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem[scan_idx] == address)) begin
                hit      = 1'b1;
                hit_data = data_mem[scan_idx];
            end
        end
    end

    assign miss_pending = memRead && !hit && !load_done_q;
    assign stall        = (memWrite && full) || miss_pending;

    always_comb begin
        readData = '0;
        if (load_done_q) begin
            readData = load_data_q;
        end else if (memRead && hit) begin
            readData = hit_data;
        end
    end

    // Next-state logic; a pending load miss beats a pending drain.
    always_comb begin
        state_d     = state_q;
        start_write = 1'b0;
        start_read  = 1'b0;
        read_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss_pending) begin
                    state_d    = StRead;
                    start_read = 1'b1;
                end else if (count_q != '0) begin
                    state_d     = StWrite;
                    start_write = 1'b1;
                end
            end
            StWrite: begin
                if (memAck) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (memAck) begin
                    state_d   = StIdle;
                    read_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage needs no reset: entries beyond count are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail_q] <= address;
            data_mem[tail_q] <= writeData;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Load-miss return: data is presented for exactly one cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            load_done_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            load_done_q <= read_done;
            if (read_done) begin
                load_data_q <= memReadData;
            end
        end
    end

    // Request registers are loaded when leaving IDLE and held until memAck,
    // so address and data are stable for the whole transaction.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (start_write) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr_mem[head_q];
                mem_wdata_q <= data_mem[head_q];
            end else if (start_read) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= address;
            end else if ((state_q != StIdle) && memAck) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
        end
    end

    assign memReq       = mem_req_q;
    assign memWe        = mem_we_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);

endmodule
